// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and RAM-side signal bundle for the load/store unit.
// The slave modport is the LSU; the master modport is the core plus data RAM.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;
  logic        rsp_oor;
  logic [1:0]  mem_we;
  logic [31:0] mem_daddr;
  logic [31:0] mem_indata;
  logic [31:0] mem_outdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_outdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_oor,
           mem_we, mem_daddr, mem_indata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_outdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_oor,
           mem_we, mem_daddr, mem_indata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store sequencer for the byte-lane data RAM.
// Splits SH into two byte writes and formats load data by size/sign.
module lsu_mem_ctrl #(
  parameter int MEM_AW  = 12,
  parameter bit CHK_OOR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LD_ADDR, LD_DATA, ST_LO, ST_HI} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_misalign_reg, rsp_misalign_next;
  logic        rsp_oor_reg, rsp_oor_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;

  logic [1:0]  mem_we_c;
  logic [31:0] mem_daddr_c, mem_indata_c;
  logic        ready, accept, req_misalign, req_oor;
  logic [7:0]  lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_fmt;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = bus.mem_outdata[8*gi +: 8];
    end
  endgenerate

  assign ready  = rst_n && (state_reg == IDLE);
  assign accept = bus.req_valid && ready;

  // Unsigned loads have no store counterpart, so 10x with we=1 is illegal.
  always_comb begin
    case (bus.req_funct3)
      3'b000:  req_misalign = 1'b0;
      3'b001:  req_misalign = bus.req_addr[0];
      3'b010:  req_misalign = |bus.req_addr[1:0];
      3'b100:  req_misalign = bus.req_we;
      3'b101:  req_misalign = bus.req_we | bus.req_addr[0];
      default: req_misalign = 1'b1;
    endcase
  end

  assign req_oor = CHK_OOR && ((bus.req_addr >> MEM_AW) != 32'd0);

  assign sel_byte = lane[addr_reg[1:0]];
  assign sel_half = addr_reg[1] ? bus.mem_outdata[31:16] : bus.mem_outdata[15:0];

  always_comb begin
    case (funct3_reg)
      3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_fmt = {24'h0, sel_byte};
      3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_fmt = {16'h0, sel_half};
      default: load_fmt = bus.mem_outdata;
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    wdata_next        = wdata_reg;
    funct3_next       = funct3_reg;
    rsp_valid_next    = 1'b0;
    rsp_misalign_next = 1'b0;
    rsp_oor_next      = 1'b0;
    rsp_rdata_next    = 32'h0;
    mem_we_c          = 2'b00;
    mem_daddr_c       = addr_reg;
    mem_indata_c      = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_misalign) begin
            rsp_valid_next    = 1'b1;
            rsp_misalign_next = 1'b1;
          end else if (req_oor) begin
            rsp_valid_next = 1'b1;
            rsp_oor_next   = 1'b1;
          end else begin
            addr_next   = bus.req_addr;
            wdata_next  = bus.req_wdata;
            funct3_next = bus.req_funct3;
            state_next  = bus.req_we ? ST_LO : LD_ADDR;
          end
        end
      end
      LD_ADDR: state_next = LD_DATA;
      LD_DATA: begin
        rsp_valid_next = 1'b1;
        rsp_rdata_next = load_fmt;
        state_next     = IDLE;
      end
      ST_LO: begin
        mem_we_c = (funct3_reg == 3'b010) ? 2'b01 : 2'b11;
        if (funct3_reg == 3'b001) begin
          state_next = ST_HI;
        end else begin
          rsp_valid_next = 1'b1;
          state_next     = IDLE;
        end
      end
      ST_HI: begin
        mem_we_c       = 2'b11;
        mem_daddr_c    = addr_reg | 32'd1;
        mem_indata_c   = {24'h0, wdata_reg[15:8]};
        rsp_valid_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      addr_reg         <= 32'h0;
      wdata_reg        <= 32'h0;
      funct3_reg       <= 3'b000;
      rsp_valid_reg    <= 1'b0;
      rsp_misalign_reg <= 1'b0;
      rsp_oor_reg      <= 1'b0;
      rsp_rdata_reg    <= 32'h0;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      wdata_reg        <= wdata_next;
      funct3_reg       <= funct3_next;
      rsp_valid_reg    <= rsp_valid_next;
      rsp_misalign_reg <= rsp_misalign_next;
      rsp_oor_reg      <= rsp_oor_next;
      rsp_rdata_reg    <= rsp_rdata_next;
    end
  end

  // The RAM must never see a write while reset is held, whatever the state.
  assign bus.mem_we       = rst_n ? mem_we_c : 2'b00;
  assign bus.mem_daddr    = mem_daddr_c;
  assign bus.mem_indata   = mem_indata_c;
  assign bus.req_ready    = ready;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_misalign = rsp_misalign_reg;
  assign bus.rsp_oor      = rsp_oor_reg;
  assign bus.rsp_rdata    = rsp_rdata_reg;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-lane RAM model (registered read).
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.MEM_AW(12), .CHK_OOR(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // RAM model: we=01 word write, we=11 byte write to lane daddr[1:0], we=00 read.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    case (bus.mem_we)
      2'b01: ram[bus.mem_daddr[11:2]] <= bus.mem_indata;
      2'b11: ram[bus.mem_daddr[11:2]][8*bus.mem_daddr[1:0] +: 8] <= bus.mem_indata[7:0];
      2'b00: bus.mem_outdata <= ram[bus.mem_daddr[11:2]];
      default: ;
    endcase
  end

  logic [1:0]  we_log [10];
  logic [31:0] da_log [10];
  logic [31:0] r_data;
  int          r_lat;
  logic        r_mis, r_oor;

  // Issue one request; log mem_we/daddr each cycle after accept until the response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    int  c;
    bit  done;
    c = 0;
    while (!bus.req_ready && c < 10) begin
      @(negedge clk);
      c++;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    r_lat = 0; r_data = 32'hx; r_mis = 1'bx; r_oor = 1'bx;
    done = 1'b0;
    c = 1;
    while (!done && c <= 10) begin
      we_log[c-1] = bus.mem_we;
      da_log[c-1] = bus.mem_daddr;
      if (bus.rsp_valid) begin
        r_lat = c; r_data = bus.rsp_rdata; r_mis = bus.rsp_misalign; r_oor = bus.rsp_oor;
        done = 1'b1;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    $display("req we=%0b f3=%03b addr=%08h wdata=%08h -> lat=%0d rdata=%08h mis=%0b oor=%0b",
             we, f3, a, wd, r_lat, r_data, r_mis, r_oor);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (bus.req_ready !== 1'b0 || bus.mem_we !== 2'b00 || bus.rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d ready=%b we=%b rsp_valid=%b req 0/00/0",
                 i, bus.req_ready, bus.mem_we, bus.rsp_valid);
      end
    end
    total++;
    if (bus.rsp_misalign !== 1'b0 || bus.rsp_oor !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rsp mis=%b oor=%b rdata=%08h req 0/0/0",
               bus.rsp_misalign, bus.rsp_oor, bus.rsp_rdata);
    end
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got=%b req=1", bus.req_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_word();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    total++;
    if (r_lat !== 2 || we_log[0] !== 2'b01 || da_log[0] !== 32'h10) begin
      bad++;
      $display("FAIL sw_timing lat=%0d we=%b daddr=%08h req 2/01/00000010",
               r_lat, we_log[0], da_log[0]);
    end
    total++;
    if (r_data !== 32'h0) begin
      bad++;
      $display("FAIL sw_rdata got=%08h req=00000000", r_data);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    total++;
    if (r_lat !== 3 || r_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lw_word lat=%0d rdata=%08h req 3/DEADBEEF", r_lat, r_data);
    end
  endtask

  task automatic test_byte();
    do_req(1'b1, 3'b000, 32'h13, 32'h000000A5);
    total++;
    if (r_lat !== 2 || we_log[0] !== 2'b11 || da_log[0] !== 32'h13) begin
      bad++;
      $display("FAIL sb_timing lat=%0d we=%b daddr=%08h req 2/11/00000013",
               r_lat, we_log[0], da_log[0]);
    end
    do_req(1'b0, 3'b000, 32'h13, 32'h0);
    total++;
    if (r_data !== 32'hFFFFFFA5) begin
      bad++;
      $display("FAIL lb_sext got=%08h req=FFFFFFA5", r_data);
    end
    // Back-to-back: the response cycle is already IDLE and ready.
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready got=%b req=1", bus.req_ready);
    end
    do_req(1'b0, 3'b100, 32'h13, 32'h0);
    total++;
    if (r_data !== 32'h000000A5) begin
      bad++;
      $display("FAIL lbu_zext got=%08h req=000000A5", r_data);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    total++;
    if (r_data !== 32'hA5ADBEEF) begin
      bad++;
      $display("FAIL lw_after_sb got=%08h req=A5ADBEEF", r_data);
    end
  endtask

  task automatic test_half();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(1'b1, 3'b001, 32'h12, 32'h00001234);
    total++;
    if (r_lat !== 3 || we_log[0] !== 2'b11 || da_log[0] !== 32'h12 ||
        we_log[1] !== 2'b11 || da_log[1] !== 32'h13) begin
      bad++;
      $display("FAIL sh_split lat=%0d we0=%b a0=%08h we1=%b a1=%08h req 3/11/12/11/13",
               r_lat, we_log[0], da_log[0], we_log[1], da_log[1]);
    end
    do_req(1'b0, 3'b001, 32'h12, 32'h0);
    total++;
    if (r_data !== 32'h00001234) begin
      bad++;
      $display("FAIL lh_hi got=%08h req=00001234", r_data);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    total++;
    if (r_data !== 32'h1234BEEF) begin
      bad++;
      $display("FAIL lw_after_sh got=%08h req=1234BEEF", r_data);
    end
    do_req(1'b0, 3'b001, 32'h10, 32'h0);
    total++;
    if (r_data !== 32'hFFFFBEEF) begin
      bad++;
      $display("FAIL lh_lo_sext got=%08h req=FFFFBEEF", r_data);
    end
    do_req(1'b0, 3'b101, 32'h10, 32'h0);
    total++;
    if (r_data !== 32'h0000BEEF) begin
      bad++;
      $display("FAIL lhu_lo got=%08h req=0000BEEF", r_data);
    end
  endtask

  task automatic test_errors();
    do_req(1'b0, 3'b010, 32'h11, 32'h0);
    total++;
    if (r_lat !== 1 || r_mis !== 1'b1 || r_oor !== 1'b0 || we_log[0] !== 2'b00 || r_data !== 32'h0) begin
      bad++;
      $display("FAIL lw_misalign lat=%0d mis=%b oor=%b we=%b rdata=%08h req 1/1/0/00/0",
               r_lat, r_mis, r_oor, we_log[0], r_data);
    end
    do_req(1'b1, 3'b001, 32'h13, 32'hFFFF);
    total++;
    if (r_lat !== 1 || r_mis !== 1'b1 || we_log[0] !== 2'b00) begin
      bad++;
      $display("FAIL sh_misalign lat=%0d mis=%b we=%b req 1/1/00", r_lat, r_mis, we_log[0]);
    end
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_misalign !== 1'b0 || bus.mem_we !== 2'b00) begin
      bad++;
      $display("FAIL rsp_pulse valid=%b mis=%b we=%b req 0/0/00",
               bus.rsp_valid, bus.rsp_misalign, bus.mem_we);
    end
    do_req(1'b0, 3'b010, 32'h1000, 32'h0);
    total++;
    if (r_lat !== 1 || r_mis !== 1'b0 || r_oor !== 1'b1 || we_log[0] !== 2'b00) begin
      bad++;
      $display("FAIL lw_oor lat=%0d mis=%b oor=%b we=%b req 1/0/1/00",
               r_lat, r_mis, r_oor, we_log[0]);
    end
    // Misalign outranks out-of-range.
    do_req(1'b1, 3'b100, 32'h2000, 32'h0);
    total++;
    if (r_mis !== 1'b1 || r_oor !== 1'b0) begin
      bad++;
      $display("FAIL err_priority mis=%b oor=%b req 1/0", r_mis, r_oor);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    total++;
    if (r_data !== 32'h1234BEEF) begin
      bad++;
      $display("FAIL lw_unchanged got=%08h req=1234BEEF", r_data);
    end
  endtask

  task automatic test_reset_mid_sh();
    do_req(1'b1, 3'b010, 32'h10, 32'h0);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0000BBAA;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_we !== 2'b11 || bus.mem_daddr !== 32'h11) begin
      bad++;
      $display("FAIL sh_hi_phase we=%b daddr=%08h req 11/00000011", bus.mem_we, bus.mem_daddr);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.mem_we !== 2'b00) begin
        bad++;
        $display("FAIL mid_reset cyc=%0d rsp_valid=%b we=%b req 0/00", i, bus.rsp_valid, bus.mem_we);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    total++;
    if (r_data !== 32'h000000AA) begin
      bad++;
      $display("FAIL lw_after_mid_reset got=%08h req=000000AA", r_data);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_mid_sh();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
